// File: rtl/bus_seq_ctrl.sv
// -----------------------------------------------------------------------------
// bus_seq_ctrl
//
// Multi-cycle instruction sequencer for a shared-bus register datapath with
// general registers R0..R(NREG-1), accumulator A, result register G and an
// add/sub/xor ALU. One instruction (func, rx, ry) is accepted per start strobe
// w while IDLE and is stepped through phases T1..T3. Illegal instructions are
// diverted to a one-cycle ERR phase.
//
// All outputs are registers. Each output register is loaded with the decode of
// the state the FSM is about to enter. The outputs therefore always describe
// the current registered state. They never depend combinationally on w, func,
// rx or ry.
//
// Ports
//   clk            in   1         rising-edge system clock
//   reset          in   1         synchronous active-high reset
//   w              in   1         start strobe, sampled only in IDLE
//   func           in   FUNC_W    000 mvi, 001 mv, 010 add, 011 xor, 100 sub
//   rx             in   5         destination / first operand register index
//   ry             in   5         source / second operand register index
//   busy           out  1         high in T1, T2, T3 and ERR
//   done           out  1         pulse in the last phase of a legal instruction
//   err            out  1         pulse when an illegal instruction is accepted
//   takedata       out  1         drive Din onto the bus
//   addorxor       out  1         ALU select: 0 add/sub, 1 xor
//   addsub         out  1         ALU mode: 0 add, 1 sub
//   reg_enable_in  out  NREG+2    load enables: [NREG-1:0] regs, NREG Gin, NREG+1 Ain
//   reg_enable_out out  NREG+1    bus drive enables: [NREG-1:0] regs, NREG Gout
// -----------------------------------------------------------------------------
module bus_seq_ctrl #(
    parameter int NREG   = 16,
    parameter int FUNC_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              w,
    input  logic [FUNC_W-1:0] func,
    input  logic [4:0]        rx,
    input  logic [4:0]        ry,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              takedata,
    output logic              addorxor,
    output logic              addsub,
    output logic [NREG+1:0]   reg_enable_in,
    output logic [NREG:0]     reg_enable_out
);

    localparam logic [FUNC_W-1:0] FN_MVI = FUNC_W'(3'd0);
    localparam logic [FUNC_W-1:0] FN_MV  = FUNC_W'(3'd1);
    localparam logic [FUNC_W-1:0] FN_ADD = FUNC_W'(3'd2);
    localparam logic [FUNC_W-1:0] FN_XOR = FUNC_W'(3'd3);
    localparam logic [FUNC_W-1:0] FN_SUB = FUNC_W'(3'd4);

    // Bit positions of the special enables.
    localparam int GIN_BIT  = NREG;
    localparam int AIN_BIT  = NREG + 1;
    localparam int GOUT_BIT = NREG;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    // Register index to one-hot select. An out-of-range index yields all zeros.
    // Such an index never reaches a legal phase, because it is rejected on accept.
    function automatic logic [NREG-1:0] reg_onehot(input logic [4:0] idx);
        logic [NREG-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) begin
            v[i] = (32'(idx) == i);
        end
        return v;
    endfunction

    // Legality check applied at the accepting edge. ry is ignored for mvi.
    function automatic logic instr_illegal(input logic [FUNC_W-1:0] f,
                                           input logic [4:0]        x,
                                           input logic [4:0]        y);
        logic bad;
        bad = 1'b0;
        if (f > FN_SUB) begin
            bad = 1'b1;
        end else if (32'(x) >= NREG) begin
            bad = 1'b1;
        end else if ((f != FN_MVI) && (32'(y) >= NREG)) begin
            bad = 1'b1;
        end else begin
            bad = 1'b0;
        end
        return bad;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [FUNC_W-1:0] r_func_q;
    logic [4:0]        r_rx_q;
    logic [4:0]        r_ry_q;
    logic [FUNC_W-1:0] w_func_nxt;
    logic [4:0]        w_rx_nxt;
    logic [4:0]        w_ry_nxt;

    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_err_nxt;
    logic              w_takedata_nxt;
    logic              w_addorxor_nxt;
    logic              w_addsub_nxt;
    logic [NREG+1:0]   w_en_in_nxt;
    logic [NREG:0]     w_en_out_nxt;
    logic [NREG-1:0]   w_rx_sel;
    logic [NREG-1:0]   w_ry_sel;
    logic              w_single_phase;

    // State register, instruction latch and registered output decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_func_q       <= '0;
            r_rx_q         <= 5'd0;
            r_ry_q         <= 5'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            takedata       <= 1'b0;
            addorxor       <= 1'b0;
            addsub         <= 1'b0;
            reg_enable_in  <= '0;
            reg_enable_out <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_func_q       <= w_func_nxt;
            r_rx_q         <= w_rx_nxt;
            r_ry_q         <= w_ry_nxt;
            busy           <= w_busy_nxt;
            done           <= w_done_nxt;
            err            <= w_err_nxt;
            takedata       <= w_takedata_nxt;
            addorxor       <= w_addorxor_nxt;
            addsub         <= w_addsub_nxt;
            reg_enable_in  <= w_en_in_nxt;
            reg_enable_out <= w_en_out_nxt;
        end
    end

    // Next-state and instruction-latch logic.
    always_comb begin
        w_state_nxt = r_state;
        w_func_nxt  = r_func_q;
        w_rx_nxt    = r_rx_q;
        w_ry_nxt    = r_ry_q;
        // mvi and mv finish in T1; the ALU ops continue to T2 and T3.
        w_single_phase = (r_func_q == FN_MVI) || (r_func_q == FN_MV);
        case (r_state)
            S_IDLE: begin
                if (w) begin
                    w_func_nxt = func;
                    w_rx_nxt   = rx;
                    w_ry_nxt   = ry;
                    if (instr_illegal(func, rx, ry)) begin
                        w_state_nxt = S_ERR;
                    end else begin
                        w_state_nxt = S_T1;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_T1: begin
                if (w_single_phase) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_T2;
                end
            end
            S_T2:    w_state_nxt = S_T3;
            S_T3:    w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode of the state being entered. The decode uses the instruction
    // that will be latched, so the registered outputs line up with the state.
    always_comb begin
        w_busy_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_takedata_nxt = 1'b0;
        w_addorxor_nxt = 1'b0;
        w_addsub_nxt   = 1'b0;
        w_en_in_nxt    = '0;
        w_en_out_nxt   = '0;
        w_rx_sel       = reg_onehot(w_rx_nxt);
        w_ry_sel       = reg_onehot(w_ry_nxt);
        case (w_state_nxt)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
            end
            S_ERR: begin
                w_busy_nxt = 1'b1;
                w_err_nxt  = 1'b1;
            end
            S_T1: begin
                w_busy_nxt = 1'b1;
                if (w_func_nxt == FN_MVI) begin
                    // Din drives the bus, so no register may drive it.
                    w_takedata_nxt          = 1'b1;
                    w_en_in_nxt[NREG-1:0]   = w_rx_sel;
                    w_done_nxt              = 1'b1;
                end else if (w_func_nxt == FN_MV) begin
                    w_en_out_nxt[NREG-1:0]  = w_ry_sel;
                    w_en_in_nxt[NREG-1:0]   = w_rx_sel;
                    w_done_nxt              = 1'b1;
                end else begin
                    // First operand goes to the accumulator.
                    w_en_out_nxt[NREG-1:0]  = w_rx_sel;
                    w_en_in_nxt[AIN_BIT]    = 1'b1;
                end
            end
            S_T2: begin
                // Second operand goes on the bus; the ALU result goes into G.
                w_busy_nxt              = 1'b1;
                w_en_out_nxt[NREG-1:0]  = w_ry_sel;
                w_en_in_nxt[GIN_BIT]    = 1'b1;
                w_addorxor_nxt          = (w_func_nxt == FN_XOR);
                w_addsub_nxt            = (w_func_nxt == FN_SUB);
            end
            S_T3: begin
                // G is written back to the destination register.
                w_busy_nxt              = 1'b1;
                w_en_out_nxt[GOUT_BIT]  = 1'b1;
                w_en_in_nxt[NREG-1:0]   = w_rx_sel;
                w_done_nxt              = 1'b1;
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // FN_ADD is listed with the other opcodes. It is the ALU default, so
    // nothing in the decode needs to test for it.
    logic w_unused_add;
    assign w_unused_add = (r_func_q == FN_ADD);

endmodule

// File: tb/tb_bus_seq_ctrl.sv
module tb_bus_seq_ctrl;

    localparam int NREG   = 16;
    localparam int FUNC_W = 3;

    logic              clk;
    logic              reset;
    logic              w;
    logic [FUNC_W-1:0] func;
    logic [4:0]        rx;
    logic [4:0]        ry;
    logic              busy;
    logic              done;
    logic              err;
    logic              takedata;
    logic              addorxor;
    logic              addsub;
    logic [NREG+1:0]   reg_enable_in;
    logic [NREG:0]     reg_enable_out;

    int errors = 0;
    int checks = 0;
    logic bus_chk_en = 1'b0;

    bus_seq_ctrl #(.NREG(NREG), .FUNC_W(FUNC_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .w             (w),
        .func          (func),
        .rx            (rx),
        .ry            (ry),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .takedata      (takedata),
        .addorxor      (addorxor),
        .addsub        (addsub),
        .reg_enable_in (reg_enable_in),
        .reg_enable_out(reg_enable_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against its expected value.
    task automatic chk_all(input string tag, input logic e_busy, input logic e_done,
                           input logic e_err, input logic e_take, input logic e_aox,
                           input logic e_as, input logic [31:0] e_in, input logic [31:0] e_out);
        chk({tag, ".busy"},     32'(busy),           32'(e_busy));
        chk({tag, ".done"},     32'(done),           32'(e_done));
        chk({tag, ".err"},      32'(err),            32'(e_err));
        chk({tag, ".takedata"}, 32'(takedata),       32'(e_take));
        chk({tag, ".addorxor"}, 32'(addorxor),       32'(e_aox));
        chk({tag, ".addsub"},   32'(addsub),         32'(e_as));
        chk({tag, ".en_in"},    32'(reg_enable_in),  e_in);
        chk({tag, ".en_out"},   32'(reg_enable_out), e_out);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus invariants, checked every cycle once reset has been applied.
    always @(negedge clk) begin
        if (bus_chk_en) begin
            checks++;
            assert ($onehot0(reg_enable_out) && !(takedata && (|reg_enable_out))
                    && ($countones(reg_enable_in) <= 2)) else begin
                errors++;
                $error("FAIL bus_invariant: en_out=0x%0h takedata=%0b en_in=0x%0h expected one driver, <=2 loads",
                       reg_enable_out, takedata, reg_enable_in);
            end
        end
    end

    initial begin
        reset = 1'b1; w = 1'b0; func = 3'd0; rx = 5'd0; ry = 5'd0;
        tick();
        tick();
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        bus_chk_en = 1'b1;
        reset = 1'b0;
        tick();
        chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // mvi R3
        w = 1'b1; func = 3'd0; rx = 5'd3; ry = 5'd0;
        tick();
        chk_all("mvi.t1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00008, 32'h0);
        w = 1'b0;
        tick();
        chk_all("mvi.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // mv R2 <- R5
        w = 1'b1; func = 3'd1; rx = 5'd2; ry = 5'd5;
        tick();
        chk_all("mv.t1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00004, 32'h00020);
        w = 1'b0;
        tick();
        chk_all("mv.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // sub R1 <- R1 - R4
        w = 1'b1; func = 3'd4; rx = 5'd1; ry = 5'd4;
        tick();
        chk_all("sub.t1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20000, 32'h00002);
        w = 1'b0;
        tick();
        chk_all("sub.t2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10000, 32'h00010);
        tick();
        chk_all("sub.t3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00002, 32'h10000);
        tick();
        chk_all("sub.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // xor R1 <- R1 ^ R4
        w = 1'b1; func = 3'd3; rx = 5'd1; ry = 5'd4;
        tick();
        chk_all("xor.t1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20000, 32'h00002);
        w = 1'b0;
        tick();
        chk_all("xor.t2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10000, 32'h00010);
        tick();
        chk_all("xor.t3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00002, 32'h10000);
        tick();

        // add R6 <- R6 + R7
        w = 1'b1; func = 3'd2; rx = 5'd6; ry = 5'd7;
        tick();
        chk_all("add.t1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20000, 32'h00040);
        w = 1'b0;
        tick();
        chk_all("add.t2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10000, 32'h00080);
        tick();
        chk_all("add.t3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00040, 32'h10000);
        tick();

        // illegal func 110
        w = 1'b1; func = 3'd6; rx = 5'd1; ry = 5'd2;
        tick();
        chk_all("ill_func.err", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        w = 1'b0;
        tick();
        chk_all("ill_func.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // add with ry=20 out of range
        w = 1'b1; func = 3'd2; rx = 5'd1; ry = 5'd20;
        tick();
        chk_all("ill_ry.err", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        w = 1'b0;
        tick();
        chk_all("ill_ry.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // mvi with rx=16 (first out-of-range index)
        w = 1'b1; func = 3'd0; rx = 5'd16; ry = 5'd0;
        tick();
        chk_all("ill_rx.err", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        w = 1'b0;
        tick();

        // mvi with ry=20 is legal (ry don't-care)
        w = 1'b1; func = 3'd0; rx = 5'd0; ry = 5'd20;
        tick();
        chk_all("mvi_ry.t1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00001, 32'h0);
        w = 1'b0;
        tick();

        // mv R15 <- R15, highest legal index, no-op move
        w = 1'b1; func = 3'd1; rx = 5'd15; ry = 5'd15;
        tick();
        chk_all("mv15.t1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h08000, 32'h08000);
        w = 1'b0;
        tick();

        // add R0 <- R0 + R9 with w/func/rx changes while busy
        w = 1'b1; func = 3'd2; rx = 5'd0; ry = 5'd9;
        tick();
        chk_all("ign.t1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20000, 32'h00001);
        func = 3'd0; rx = 5'd3; ry = 5'd3;
        tick();
        chk_all("ign.t2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10000, 32'h00200);
        w = 1'b0;
        tick();
        chk_all("ign.t3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00001, 32'h10000);
        tick();
        chk_all("ign.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // reset during T2 of an add
        w = 1'b1; func = 3'd2; rx = 5'd1; ry = 5'd2;
        tick();
        w = 1'b0;
        tick();
        chk_all("rst_mid.t2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10000, 32'h00004);
        reset = 1'b1;
        tick();
        chk_all("rst_mid.rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        tick();
        chk_all("rst_mid.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // back-to-back mvi with w held high
        w = 1'b1; func = 3'd0; rx = 5'd7; ry = 5'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("b2b.t1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00080, 32'h0);
            tick();
            chk_all("b2b.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        w = 1'b0;
        tick();
        chk_all("b2b.end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_seq_ctrl.md
Name: bus_seq_ctrl

Overview:
- Multi-cycle instruction sequencer for the shared-bus register datapath: general registers R0..R(NREG-1), accumulator A, result register G, an add/sub/xor ALU, and an external data input Din.
- Accepts one instruction per start pulse (w, func, rx, ry) and steps the datapath through timed phases T1..T3.
- Drives one-hot bus-out enables and per-register load enables, then signals completion.
- Replaces the single-cycle blocking-assignment controller with a clean registered FSM.

Parameters:
- NREG, 16, number of general registers; register indices are 0..NREG-1.
- FUNC_W, 3, width of the func opcode.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- w  in  1  start strobe; sampled only in IDLE.
- func  in  FUNC_W  opcode: 000 mvi (Din->rx), 001 mv (ry->rx), 010 add, 011 xor, 100 sub; 101..111 illegal.
- rx  in  5  destination / first-operand register index.
- ry  in  5  second-operand / source register index.
- busy  out  1  high while in T1, T2, T3 or ERR.
- done  out  1  one-cycle pulse in the last phase of a legal instruction.
- err  out  1  one-cycle pulse when an illegal instruction is accepted.
- takedata  out  1  drives Din onto the bus.
- addorxor  out  1  ALU select: 0 = add/sub, 1 = xor.
- addsub  out  1  ALU arithmetic mode: 0 = add, 1 = sub.
- reg_enable_in  out  NREG+2  load enables: bits [NREG-1:0] are the registers, bit NREG is Gin, bit NREG+1 is Ain.
- reg_enable_out  out  NREG+1  bus drive enables: bits [NREG-1:0] are the registers, bit NREG is Gout.

Behaviour:
- States: IDLE, T1, T2, T3, ERR. State and latched instruction (func_q, rx_q, ry_q) are registered.
- All outputs are decoded from registered state only; no output depends combinationally on w, func, rx or ry.
- Reset:
  - Takes effect on the next rising edge with reset=1; overrides everything, including mid-instruction.
  - After that edge: state=IDLE and every output is 0, including all enable bits, takedata, addorxor, addsub, busy, done, err.
  - The aborted instruction is dropped; no done and no err is issued for it.
- IDLE:
  - All outputs 0.
  - On w=1: latch func, rx, ry.
  - Instruction is illegal if func>=101, or rx>=NREG, or (func!=000 and ry>=NREG); ry is don't-care for mvi.
  - Next state: ERR if illegal, else T1.
- ERR: err=1, busy=1, all enables 0; next state IDLE.
- mvi, T1: takedata=1, reg_enable_in[rx_q]=1, done=1; next state IDLE.
- mv, T1:
  - reg_enable_out[ry_q]=1, reg_enable_in[rx_q]=1, done=1; next state IDLE.
  - rx_q==ry_q is legal and is a no-op move.
- add/xor/sub:
  - T1: reg_enable_out[rx_q]=1, Ain=1.
  - T2: reg_enable_out[ry_q]=1, Gin=1. addorxor=1 only for xor; addsub=1 only for sub; both 0 for add.
  - T3: Gout=1, reg_enable_in[rx_q]=1, done=1; next state IDLE.
  - addorxor and addsub are 0 in every state other than T2.
- Invariants:
  - At most one bit of reg_enable_out is high, and takedata is never high in the same cycle as any reg_enable_out bit (single bus driver).
  - At most two bits of reg_enable_in are high.
- Latency, counted from the accepting edge (w=1 in IDLE):
  - mvi/mv: done in the 1st following cycle.
  - ALU ops: done in the 3rd following cycle.
  - Illegal: err in the 1st following cycle.
  - Next accept can occur in the IDLE cycle immediately after done or err.
- w while busy is ignored; it is not queued. func, rx and ry changes after acceptance have no effect.
- w held high continuously re-accepts on every IDLE cycle.

Test Plan:
- reset=1 for 2 cycles, then 0 -> every output 0; w=1, func=000, rx=3 -> next cycle takedata=1, reg_enable_in=0x00008, done=1; following cycle all outputs 0.
- func=001, rx=2, ry=5 -> T1: reg_enable_out=0x00020, reg_enable_in=0x00004, done=1, busy=1.
- func=100, rx=1, ry=4 ->
  - T1: reg_enable_out=0x00002, reg_enable_in=0x20000.
  - T2: reg_enable_out=0x00010, reg_enable_in=0x10000, addsub=1, addorxor=0.
  - T3: reg_enable_out=0x10000, reg_enable_in=0x00002, done=1.
  - Repeat with func=011: addorxor=1 and addsub=0 in T2.
- func=110, or func=010 with ry=20 -> err=1 for one cycle, all enables 0, no done, back to IDLE.
- Start add, assert w=1 with func=000 during T1 and T2 -> ignored; only the add completes. Assert reset during T2 -> next cycle IDLE, all outputs 0, no done.
- Back-to-back: w held 1, func=000 -> alternating T1 (done=1) / IDLE cycles; a bus checker confirms one-hot reg_enable_out throughout all scenarios.
